// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the SimpleRISC operand-fetch stage: instruction field
// positions, immediate modes and a register-index range helper.
package of_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_HIGH = 2'b10,
    IMM_RSVD = 2'b11
  } imm_mode_e;

  // Stores carry their data register in the rd slot, so rs2 is taken from here when is_st.
  localparam int RD_MSB       = 25;
  localparam int RD_LSB       = 22;
  localparam int RS1_MSB      = 21;
  localparam int RS1_LSB      = 18;
  localparam int RS2_MSB      = 17;
  localparam int RS2_LSB      = 14;
  localparam int IMM_MODE_MSB = 17;
  localparam int IMM_MODE_LSB = 16;
  localparam int IMM_MSB      = 15;
  localparam int IMM_LSB      = 0;
  localparam int OFFSET_W     = 27;

  function automatic logic idx_ok(input logic [3:0] idx, input int nregs);
    return (int'(idx) < nregs);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side, writeback-side and execute-side signals of the operand-fetch stage.
interface operand_fetch_stage_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            is_ret;
  logic            is_st;
  logic            use1;
  logic            use2;
  logic            wr_en;
  logic [3:0]      rd;
  logic            wb_en;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_immx;
  logic [XLEN-1:0] out_branch_target;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_rd;
  logic            out_wr_en;

  modport master (
    output in_valid, inst, pc, is_ret, is_st, use1, use2, wr_en, rd,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_immx, out_branch_target,
    input  out_pc, out_rd, out_wr_en
  );

  modport slave (
    input  in_valid, inst, pc, is_ret, is_st, use1, use2, wr_en, rd,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_immx, out_branch_target,
    output out_pc, out_rd, out_wr_en
  );

endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// Per-register busy bits and RAW/WAW hazard detection for the operand-fetch stage.
// With OF_BYPASS_EN a same-cycle writeback hides the busy bit of a matching source.
module of_scoreboard
  import of_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  logic [3:0] rd,
  input  logic       use1,
  input  logic       use2,
  input  logic       wr_en,
  input  logic       accept,
  input  logic       wb_en,
  input  logic [3:0] wb_addr,
  output logic       hazard
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic             fwd1_s;
  logic             fwd2_s;

  function automatic logic lookup(input logic [NREGS-1:0] vec, input logic [3:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      hit = hit | (vec[i] & (idx == 4'(i)));
    end
    return hit;
  endfunction

`ifdef OF_BYPASS_EN
  assign fwd1_s = wb_en && (wb_addr == rs1);
  assign fwd2_s = wb_en && (wb_addr == rs2);
`else
  assign fwd1_s = 1'b0;
  assign fwd2_s = 1'b0;
`endif

  // Next busy vector: a set from an accepted writer beats a same-edge clear.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      busy_nxt_s[i] = (accept && wr_en && (rd == 4'(i))) ||
                      (busy_r[i] && !(wb_en && (wb_addr == 4'(i))));
    end
  end

  // Hazard compare against the current busy vector.
  always_comb begin
    hazard = (use1  && lookup(busy_r, rs1) && !fwd1_s) ||
             (use2  && lookup(busy_r, rs2) && !fwd2_s) ||
             (wr_en && lookup(busy_r, rd));
  end

  // Busy-bit state register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// SimpleRISC operand-fetch stage: register file, scoreboard, immediate and branch decode,
// one registered bundle per accepted instruction. Optional forwarding: OF_BYPASS_EN.
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int RET_REG = NREGS - 1
) (
  input logic                  clk,
  input logic                  Reset,
  operand_fetch_stage_if.slave bus
);

  logic [XLEN-1:0] regfile_r [NREGS];
  logic [3:0]      rs1_s;
  logic [3:0]      rs2_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
  logic [XLEN-1:0] immx_s;
  logic [XLEN-1:0] offset_s;
  logic [XLEN-1:0] target_s;
  logic [15:0]     imm_s;
  imm_mode_e       mode_s;
  logic            hazard_s;
  logic            accept_s;
  logic            unused_s;

  function automatic logic [XLEN-1:0] read_reg(input logic [3:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      v = v | (regfile_r[i] & {XLEN{idx == 4'(i)}});
    end
    return v;
  endfunction

  assign rs1_s    = bus.is_ret ? 4'(RET_REG) : bus.inst[RS1_MSB:RS1_LSB];
  assign rs2_s    = bus.is_st ? bus.inst[RD_MSB:RD_LSB] : bus.inst[RS2_MSB:RS2_LSB];
  assign imm_s    = bus.inst[IMM_MSB:IMM_LSB];
  assign mode_s   = imm_mode_e'(bus.inst[IMM_MODE_MSB:IMM_MODE_LSB]);
  assign offset_s = {{(XLEN-OFFSET_W){bus.inst[OFFSET_W-1]}}, bus.inst[OFFSET_W-1:0]};
  assign target_s = bus.pc + (offset_s << 2);
  assign unused_s = ^bus.inst[31:OFFSET_W];

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard_s;
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Source operand read, with optional same-cycle writeback forwarding.
  always_comb begin
    op1_s = read_reg(rs1_s);
    op2_s = read_reg(rs2_s);
`ifdef OF_BYPASS_EN
    if (bus.wb_en && idx_ok(bus.wb_addr, NREGS) && (bus.wb_addr == rs1_s)) begin
      op1_s = bus.wb_data;
    end else begin
      op1_s = read_reg(rs1_s);
    end
    if (bus.wb_en && idx_ok(bus.wb_addr, NREGS) && (bus.wb_addr == rs2_s)) begin
      op2_s = bus.wb_data;
    end else begin
      op2_s = read_reg(rs2_s);
    end
`endif
  end

  // Immediate extension by mode.
  always_comb begin
    immx_s = '0;
    case (mode_s)
      IMM_SEXT: immx_s = {{(XLEN-16){imm_s[15]}}, imm_s};
      IMM_ZEXT: immx_s[15:0] = imm_s;
      IMM_HIGH: immx_s[31:16] = imm_s;
      IMM_RSVD: immx_s = '0;
      default:  immx_s = '0;
    endcase
  end

  of_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk     (clk),
    .Reset   (Reset),
    .rs1     (rs1_s),
    .rs2     (rs2_s),
    .rd      (bus.rd),
    .use1    (bus.use1),
    .use2    (bus.use2),
    .wr_en   (bus.wr_en),
    .accept  (accept_s),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .hazard  (hazard_s)
  );

  // Register file write port; out-of-range indices are dropped.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regfile_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.wb_en && (bus.wb_addr == 4'(i))) begin
          regfile_r[i] <= bus.wb_data;
        end
      end
    end
  end

  // Output bundle: loads on acceptance, drains when consumed, holds under backpressure.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      bus.out_valid         <= 1'b0;
      bus.out_op1           <= '0;
      bus.out_op2           <= '0;
      bus.out_immx          <= '0;
      bus.out_branch_target <= '0;
      bus.out_pc            <= '0;
      bus.out_rd            <= 4'h0;
      bus.out_wr_en         <= 1'b0;
    end else if (accept_s) begin
      bus.out_valid         <= 1'b1;
      bus.out_op1           <= op1_s;
      bus.out_op2           <= op2_s;
      bus.out_immx          <= immx_s;
      bus.out_branch_target <= target_s;
      bus.out_pc            <= bus.pc;
      bus.out_rd            <= bus.rd;
      bus.out_wr_en         <= bus.wr_en;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid         <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Parametrised, pipelined operand-fetch stage for the SimpleRISC core. It holds the architectural register file and a per-register scoreboard, and decodes immediates and branch targets. It presents one registered operand bundle per accepted instruction to the execute stage over a valid/ready handshake. It sits between decode and execute, and takes writebacks directly from the writeback stage.

## Interface
Parameters:
- XLEN, 32: datapath width; legal range 32..64.
- NREGS, 16: number of implemented registers; legal range 2..16. Indices ≥ NREGS read as 0 and writes to them are ignored.
- RET_REG, NREGS-1: register read as rs1 when `is_ret` is set.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  instruction PC.
- is_ret, is_st  in  1  source-select controls.
- use1, use2  in  1  rs1 / rs2 are real sources, used for hazard checks.
- wr_en  in  1  instruction writes `rd`.
- rd  in  4  destination index; supplied by decode so calls can target RET_REG.
- wb_en  in  1  writeback strobe.
- wb_addr  in  4  writeback index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute consumes.
- out_op1, out_op2  out  XLEN  operands.
- out_immx  out  XLEN  extended immediate.
- out_branch_target  out  XLEN  branch target.
- out_pc  out  XLEN  carried PC.
- out_rd  out  4  carried destination.
- out_wr_en  out  1  carried write flag.

## Operation
- Source fields:
  - rs1 = `is_ret` ? RET_REG : inst[21:18].
  - rs2 = `is_st` ? inst[25:22] : inst[17:14].
- Immediate, keyed on mode inst[17:16] with value inst[15:0]:
  - 00: sign-extend to XLEN.
  - 01: zero-extend.
  - 10: value in bits [31:16], bits [15:0] = 0, bits above 31 = 0.
  - 11: all zeros.
- Branch target: pc + (sign-extended inst[26:0] << 2), modulo 2^XLEN.
- Scoreboard: one busy bit per register.
  - Set on acceptance when wr_en = 1.
  - Cleared on writeback to that index.
  - If set and clear hit the same index on the same edge, set wins.
- Hazard is asserted when any of these hold:
  - use1 && busy[rs1]
  - use2 && busy[rs2]
  - wr_en && busy[rd] (WAW; this guarantees at most one in-flight writer per register)
- `in_ready = (!out_valid || out_ready) && !hazard`.
- On acceptance (`in_valid && in_ready`), the output register loads the operands, immediate, target, pc, rd and wr_en, and out_valid goes to 1.
- If `out_valid && out_ready && !in_valid`, out_valid goes to 0.
- The output bundle holds stable while `out_valid && !out_ready`.
- Register write: `regfile[wb_addr] <= wb_data` on the edge when wb_en = 1 and wb_addr < NREGS.

## Timing
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction per cycle when there are no hazards and out_ready stays high.
- Without bypass, a writeback to a source register makes the new value readable, and clears the hazard, on the following cycle. A dependent instruction therefore stalls until the cycle after wb_en.
- Reset values: every register = 0, all busy bits = 0, out_valid = 0, and all out_* data outputs = 0.
- Reset asserted mid-operation discards the pending bundle and all scoreboard state immediately. No writeback is lost architecturally, because the register file is cleared anyway.
- A writeback to an index that is not busy updates the register and leaves the scoreboard unchanged.

## Configuration
- OF_BYPASS_EN defined:
  - A same-cycle writeback whose wb_addr matches rs1 or rs2 forwards wb_data into the captured operand.
  - The matching busy bit is treated as clear for that cycle's hazard check. A dependent instruction accepts in the same cycle as its producer's writeback.
- OF_BYPASS_EN undefined:
  - No forwarding; the one-extra-cycle stall described under Timing applies.

## Structure
- Package `of_pkg` holds:
  - the imm_mode enum (IMM_SEXT, IMM_ZEXT, IMM_HIGH, IMM_RSVD);
  - field-position constants (RD_MSB/LSB, RS1_MSB/LSB, RS2_MSB/LSB, IMM_MODE_MSB/LSB, OFFSET_W = 27).
- Sub-module `of_scoreboard` contains the busy-bit vector, the set/clear priority, and the hazard compare. Its inputs are rs1, rs2, rd, the use/wr flags, the accept strobe and the writeback.

## Test plan
- Reset, then inst with rs1=3, rs2=4, use1=use2=1 -> out_op1 = 0, out_op2 = 0, out_valid 1 cycle after acceptance.
- Writeback R5 = 0x1234, then an instruction with rs1=5 -> out_op1 = 0x1234.
- Immediate modes:
  - mode 00, imm 0x8000 -> immx = 0xFFFF8000;
  - mode 10, imm 0x00AB -> immx = 0x00AB0000;
  - mode 11 -> immx = 0.
- Branch target: pc = 0x100, inst[26:0] = 0x7FFFFFF -> target = 0xFC.
- Scoreboard: accept a writer with wr_en=1, rd=2, then a reader with use1=1, rs1=2.
  - The reader is held with in_ready = 0 until wb_en, wb_addr = 2.
  - It is accepted on the same cycle with OF_BYPASS_EN (op1 = wb_data), or one cycle later without it.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> bundle stable, in_ready = 0. Assert Reset mid-stall -> out_valid = 0 and all busy bits clear.
